// File: rtl/dmem_arbiter.sv
// Two-requester round-robin front end for a single-port, byte-enabled data memory.
// Formats stores into lanes/enables and aligns/extends registered read data.
module dmem_arbiter #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic        r0_we,
    input  logic [1:0]  r0_size,
    input  logic        r0_unsigned,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_rvalid,
    output logic [31:0] r0_rdata,
    output logic        r0_err,

    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic        r1_we,
    input  logic [1:0]  r1_size,
    input  logic        r1_unsigned,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_rvalid,
    output logic [31:0] r1_rdata,
    output logic        r1_err,

    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [1:0]  SIZE_BYTE   = 2'b00;
    localparam logic [1:0]  SIZE_HALF   = 2'b01;
    localparam logic [1:0]  SIZE_WORD   = 2'b10;
    localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);

    // Requests gathered into indexable form so both ports share one decoder body.
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [1:0]  req_unsigned;
    logic [1:0]  req_size  [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];

    assign req_valid    = {r1_valid, r0_valid};
    assign req_we       = {r1_we, r0_we};
    assign req_unsigned = {r1_unsigned, r0_unsigned};
    assign req_size[0]  = r0_size;
    assign req_size[1]  = r1_size;
    assign req_addr[0]  = r0_addr;
    assign req_addr[1]  = r1_addr;
    assign req_wdata[0] = r0_wdata;
    assign req_wdata[1] = r1_wdata;

    logic [1:0]  req_err;
    logic [3:0]  req_be [2];
    logic [31:0] req_wd [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_decode
            logic [1:0] off;
            logic       misaligned;
            logic       out_of_range;

            assign off          = req_addr[gi][1:0];
            assign out_of_range = (req_addr[gi][31:2] >= DEPTH_LIMIT);
            assign req_err[gi]  = misaligned | out_of_range;

            always_comb begin
                misaligned = 1'b0;
                case (req_size[gi])
                    SIZE_BYTE: misaligned = 1'b0;
                    SIZE_HALF: misaligned = off[0];
                    SIZE_WORD: misaligned = |off;
                    default:   misaligned = 1'b1;
                endcase
            end

            // Store data is replicated across all lanes; the enables pick the live ones.
            always_comb begin
                req_be[gi] = 4'b0000;
                req_wd[gi] = 32'h0;
                case (req_size[gi])
                    SIZE_BYTE: begin
                        req_be[gi] = 4'b0001 << off;
                        req_wd[gi] = {4{req_wdata[gi][7:0]}};
                    end
                    SIZE_HALF: begin
                        req_be[gi] = off[1] ? 4'b1100 : 4'b0011;
                        req_wd[gi] = {2{req_wdata[gi][15:0]}};
                    end
                    SIZE_WORD: begin
                        req_be[gi] = 4'b1111;
                        req_wd[gi] = req_wdata[gi];
                    end
                    default: begin
                        req_be[gi] = 4'b0000;
                        req_wd[gi] = 32'h0;
                    end
                endcase
            end
        end
    endgenerate

    // Arbitration: the port that was not served last wins a tie.
    logic last_grant_reg;
    logic last_grant_next;
    logic grant_sel;
    logic accept;

    always_comb begin
        if (&req_valid) begin
            grant_sel = ~last_grant_reg;
        end else begin
            grant_sel = req_valid[1];
        end
        accept          = (|req_valid) & ~reset;
        last_grant_next = accept ? grant_sel : last_grant_reg;
    end

    assign r0_ready = accept & ~grant_sel;
    assign r1_ready = accept & grant_sel;

    logic        sel_we;
    logic        sel_err;
    logic        sel_unsigned;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;

    always_comb begin
        sel_we       = req_we[grant_sel];
        sel_err      = req_err[grant_sel];
        sel_unsigned = req_unsigned[grant_sel];
        sel_size     = req_size[grant_sel];
        sel_addr     = req_addr[grant_sel];
    end

    always_comb begin
        mem_we = 1'b0;
        mem_be = 4'b0000;
        mem_a  = 32'h0;
        mem_wd = 32'h0;
        if (accept) begin
            mem_a = sel_addr;
            if (sel_we && !sel_err) begin
                mem_we = 1'b1;
                mem_be = req_be[grant_sel];
                mem_wd = req_wd[grant_sel];
            end
        end
    end

    // Response pipeline: one slot, since memory read latency is exactly one cycle.
    logic       resp_valid_reg;
    logic       resp_owner_reg;
    logic       resp_we_reg;
    logic [1:0] resp_size_reg;
    logic       resp_unsigned_reg;
    logic [1:0] resp_off_reg;
    logic       resp_err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_reg    <= 1'b1;
            resp_valid_reg    <= 1'b0;
            resp_owner_reg    <= 1'b0;
            resp_we_reg       <= 1'b0;
            resp_size_reg     <= 2'b00;
            resp_unsigned_reg <= 1'b0;
            resp_off_reg      <= 2'b00;
            resp_err_reg      <= 1'b0;
        end else begin
            last_grant_reg <= last_grant_next;
            resp_valid_reg <= accept;
            if (accept) begin
                resp_owner_reg    <= grant_sel;
                resp_we_reg       <= sel_we;
                resp_size_reg     <= sel_size;
                resp_unsigned_reg <= sel_unsigned;
                resp_off_reg      <= sel_addr[1:0];
                resp_err_reg      <= sel_err;
            end
        end
    end

    logic [31:0] rd_shifted;
    logic [31:0] load_data;

    always_comb begin
        rd_shifted = mem_rd >> {resp_off_reg, 3'b000};
        load_data  = 32'h0;
        if (!resp_we_reg && !resp_err_reg) begin
            case (resp_size_reg)
                SIZE_BYTE: load_data = resp_unsigned_reg ? {24'h0, rd_shifted[7:0]}
                                                         : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
                SIZE_HALF: load_data = resp_unsigned_reg ? {16'h0, rd_shifted[15:0]}
                                                         : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
                SIZE_WORD: load_data = mem_rd;
                default:   load_data = 32'h0;
            endcase
        end
    end

    // Reset also masks a response already in flight so it never reaches a requester.
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_err;
    logic [31:0] rsp_data [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            logic owned;
            assign owned         = (gi == 1) ? resp_owner_reg : ~resp_owner_reg;
            assign rsp_valid[gi] = resp_valid_reg & owned & ~reset;
            assign rsp_err[gi]   = rsp_valid[gi] & resp_err_reg;
            assign rsp_data[gi]  = rsp_valid[gi] ? load_data : 32'h0;
        end
    endgenerate

    assign r0_rvalid = rsp_valid[0];
    assign r0_err    = rsp_err[0];
    assign r0_rdata  = rsp_data[0];
    assign r1_rvalid = rsp_valid[1];
    assign r1_err    = rsp_err[1];
    assign r1_rdata  = rsp_data[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic, checked
// against a byte-array memory model and a one-deep expected-response slot.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_valid, r0_ready, r0_we, r0_unsigned, r0_rvalid, r0_err;
    logic [1:0]  r0_size;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;
    logic        r1_valid, r1_ready, r1_we, r1_unsigned, r1_rvalid, r1_err;
    logic [1:0]  r1_size;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_a, mem_wd;
    logic [31:0] mem_rd = 32'h0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH_WORDS(64)) dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_size(r0_size),
        .r0_unsigned(r0_unsigned), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_size(r1_size),
        .r1_unsigned(r1_unsigned), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .mem_we(mem_we), .mem_be(mem_be), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Memory the DUT drives: 64 words, byte enables, registered read.
    logic [31:0] env_mem [64] = '{default: 32'h0};
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (mem_we && mem_be[k]) env_mem[mem_a[7:2]][8*k +: 8] <= mem_wd[8*k +: 8];
        mem_rd <= env_mem[mem_a[7:2]];
    end

    logic [7:0]  ref_mem [256];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        exp_last   = 1'b1;
    logic        pend_valid = 1'b0;
    logic        pend_owner = 1'b0;
    logic        pend_err   = 1'b0;
    logic [31:0] pend_data  = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input int p, input logic v, input logic we, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            r0_valid = v; r0_we = we; r0_size = sz; r0_unsigned = u; r0_addr = a; r0_wdata = d;
        end else begin
            r1_valid = v; r1_we = we; r1_size = sz; r1_unsigned = u; r1_addr = a; r1_wdata = d;
        end
    endtask

    task automatic idle();
        req(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        req(1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    endtask

    // Called just after the negedge with inputs applied; checks this cycle, advances one clock.
    task automatic tick();
        logic        g, acc, we, u, err, nv, no, ne;
        logic [1:0]  sz;
        logic [31:0] a, d, v, be32, wd, nd;
        int          nb;
        #1;
        g   = (r0_valid && r1_valid) ? ~exp_last : (r1_valid && !r0_valid);
        acc = (r0_valid || r1_valid) && !reset;
        chk("r0_ready", 32'(r0_ready), 32'(acc && !g));
        chk("r1_ready", 32'(r1_ready), 32'(acc && g));

        chk("r0_rvalid", 32'(r0_rvalid), 32'(pend_valid && !pend_owner && !reset));
        chk("r1_rvalid", 32'(r1_rvalid), 32'(pend_valid && pend_owner && !reset));
        if (pend_valid && !reset) begin
            chk("rsp_rdata", pend_owner ? r1_rdata : r0_rdata, pend_data);
            chk("rsp_err", 32'(pend_owner ? r1_err : r0_err), 32'(pend_err));
        end else begin
            chk("idle_rdata", r0_rdata | r1_rdata, 32'h0);
            chk("idle_err", 32'(r0_err | r1_err), 32'h0);
        end

        nv = 1'b0; no = 1'b0; ne = 1'b0; nd = 32'h0;
        if (acc) begin
            we = g ? r1_we : r0_we;   sz = g ? r1_size : r0_size;
            u  = g ? r1_unsigned : r0_unsigned;
            a  = g ? r1_addr : r0_addr; d = g ? r1_wdata : r0_wdata;
            nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            err = (sz == 2'd3) || ((a % 32'(nb)) != 0) || ((a >> 2) >= 32'd64);
            chk("mem_a", mem_a, a);
            be32 = 32'h0; wd = 32'h0;
            if (we && !err) begin
                for (int i = 0; i < nb; i++) be32[int'(a[1:0]) + i] = 1'b1;
                for (int k = 0; k < 4; k++) wd[8*k +: 8] = d[8*(k % nb) +: 8];
                chk("mem_wd", mem_wd, wd);
            end
            chk("mem_we", 32'(mem_we), 32'(we && !err));
            chk("mem_be", 32'(mem_be), be32);
            v = 32'h0;
            if (!err && !we) begin
                for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[int'(a[7:0]) + i]) << (8*i));
                if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            end
            if (!err && we)
                for (int i = 0; i < nb; i++) ref_mem[int'(a[7:0]) + i] = d[8*i +: 8];
            nv = 1'b1; no = g; ne = err; nd = v;
            exp_last = g;
        end else begin
            chk("idle_mem_we", 32'(mem_we), 32'h0);
            chk("idle_mem_be", 32'(mem_be), 32'h0);
            chk("idle_mem_a", mem_a, 32'h0);
        end
        if (reset) begin
            exp_last = 1'b1;
            nv = 1'b0;
        end
        @(posedge clk);
        pend_valid = nv; pend_owner = no; pend_err = ne; pend_data = nd;
        @(negedge clk);
    endtask

    initial begin
        logic [1:0]  rs;
        logic [31:0] ra;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        reset = 1'b1;
        idle();
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;

        // Word store then load of the same word.
        req(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF); tick();
        req(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);         tick();
        idle(); tick();

        // Byte store into a zero word, signed and unsigned byte loads.
        req(0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_0080); tick();
        req(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0);         tick();
        req(0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0);         tick();
        idle(); tick();

        // Contention straight after reset: r0, r1, r0, r1.
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
            req(1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
            tick();
        end
        idle(); tick();

        // r1 error cases: misaligned half, out-of-range word, illegal size.
        req(1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h03, 32'h0);  tick();
        req(1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'h1); tick();
        req(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0); tick();
        req(1, 1'b1, 1'b1, 2'b11, 1'b0, 32'h08, 32'h5);  tick();
        idle(); tick();

        // Upper half store then immediate signed half load.
        req(0, 1'b1, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_ABCD); tick();
        req(0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);         tick();
        idle(); tick();

        // Reset lands while a load response is pending.
        req(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0); tick();
        idle(); reset = 1'b1; tick();
        reset = 1'b0; tick();
        req(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        req(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        tick();
        idle(); tick();

        // Random traffic with occasional errors and resets.
        for (int n = 0; n < 500; n++) begin
            for (int p = 0; p < 2; p++) begin
                rs = ($urandom_range(0, 11) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                ra = 32'($urandom_range(0, 255));
                if ($urandom_range(0, 3) != 0 && rs != 2'b11)
                    ra = (rs == 2'b01) ? (ra & ~32'h1) : (rs == 2'b10) ? (ra & ~32'h3) : ra;
                if ($urandom_range(0, 15) == 0) ra = $urandom;
                req(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rs,
                    1'($urandom_range(0, 1)), ra, $urandom);
            end
            reset = ($urandom_range(0, 63) == 0);
            tick();
        end
        reset = 1'b0;
        idle(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
